tpu_regbank: RTL and testbench

Parametrised, multi-channel register bank for the timer/TPU peripheral. It sits between the 8-bit system register bus (`addr`/`data_in`/`we`/`data_out`) and NCH TPU channels. Each channel has its own control, TX/RX slot and 2-word interval registers. The bank adds four behaviours:
- sticky write-1-to-clear interrupt flags with per-channel masks and an aggregated `irq`;
- atomic commit of the interval value;
- self-clearing per-channel reset pulses;
- a global interrupt status register.

---
 rtl/tpu_regbank.sv | 162 ++++++++++++++++
 tb/tb_tpu_regbank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_regbank.sv
// Register bank for NCH TPU channels: CTRL/TX/RX/interval registers, W1C interrupt flags, IRQ status.
// Read data registered, 1-cycle latency; writes take effect at the sampling edge; no backpressure.
module tpu_regbank #(
  parameter int          NCH       = 4,
  parameter int          DW        = 8,
  parameter int          AW        = 8,
  parameter int unsigned BASE_ADDR = 32'h20
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic [DW-1:0]         data_in,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  output logic [DW-1:0]         data_out,
  input  logic [NCH-1:0]        intflag,
  output logic [NCH-1:0]        txslot_en,
  output logic [NCH-1:0]        rxslot_en,
  output logic [NCH*DW-1:0]     tx_slot,
  output logic [NCH*DW-1:0]     rx_slot,
  output logic [NCH*2*DW-1:0]   tpuint,
  output logic [NCH-1:0]        rsttpu,
  output logic                  irq
);

  localparam int unsigned STAT_ADDR = BASE_ADDR + 32'(8 * NCH);
  localparam int unsigned PEND_ADDR = STAT_ADDR + 32'd1;

  function automatic logic [AW-1:0] reg_addr(input int ch, input int off);
    return AW'(BASE_ADDR + 32'(8 * ch + off));
  endfunction

  // Per-channel state
  logic [NCH-1:0] txen_q, txen_d;
  logic [NCH-1:0] rxen_q, rxen_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] flag_q, flag_d;
  logic [NCH-1:0] rst_q,  rst_d;
  logic [DW-1:0]  tx_q     [NCH];
  logic [DW-1:0]  tx_d     [NCH];
  logic [DW-1:0]  rx_q     [NCH];
  logic [DW-1:0]  rx_d     [NCH];
  logic [DW-1:0]  shadow_q [NCH];
  logic [DW-1:0]  shadow_d [NCH];
  logic [DW-1:0]  int0_q   [NCH];
  logic [DW-1:0]  int0_d   [NCH];
  logic [DW-1:0]  int1_q   [NCH];
  logic [DW-1:0]  int1_d   [NCH];
  logic [DW-1:0]  dout_q,  dout_d;

  // Address decode
  logic [NCH-1:0] sel_ctrl, sel_tx, sel_rx, sel_int0, sel_int1;
  logic           sel_stat, sel_pend;

  always_comb begin
    sel_ctrl = '0;
    sel_tx   = '0;
    sel_rx   = '0;
    sel_int0 = '0;
    sel_int1 = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_ctrl[i] = (addr == reg_addr(i, 0));
      sel_tx[i]   = (addr == reg_addr(i, 1));
      sel_rx[i]   = (addr == reg_addr(i, 2));
      sel_int0[i] = (addr == reg_addr(i, 3));
      sel_int1[i] = (addr == reg_addr(i, 4));
    end
    sel_stat = (addr == AW'(STAT_ADDR));
    sel_pend = (addr == AW'(PEND_ADDR));
  end

  // Read mux sees pre-write state, so a same-edge read returns the old value
  always_comb begin
    dout_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_ctrl[i]) begin
        dout_d[1] = txen_q[i];
        dout_d[2] = rxen_q[i];
        dout_d[3] = mask_q[i];
        dout_d[4] = flag_q[i];
      end
      if (sel_tx[i])   dout_d = tx_q[i];
      if (sel_rx[i])   dout_d = rx_q[i];
      if (sel_int0[i]) dout_d = int0_q[i];
      if (sel_int1[i]) dout_d = int1_q[i];
    end
    if (sel_stat) dout_d[NCH-1:0] = flag_q;
    if (sel_pend) dout_d[NCH-1:0] = flag_q & mask_q;
  end

  always_comb begin
    txen_d   = txen_q;
    rxen_d   = rxen_q;
    mask_d   = mask_q;
    flag_d   = flag_q;
    rst_d    = '0;
    tx_d     = tx_q;
    rx_d     = rx_q;
    shadow_d = shadow_q;
    int0_d   = int0_q;
    int1_d   = int1_q;
    for (int i = 0; i < NCH; i++) begin
      if (we && sel_ctrl[i]) begin
        rst_d[i]  = data_in[0];
        txen_d[i] = data_in[1];
        rxen_d[i] = data_in[2];
        mask_d[i] = data_in[3];
        if (data_in[4]) flag_d[i] = 1'b0;
      end
      if (we && sel_tx[i])   tx_d[i]     = data_in;
      if (we && sel_rx[i])   rx_d[i]     = data_in;
      if (we && sel_int0[i]) shadow_d[i] = data_in;
      // Commit both interval words together on the high-word write
      if (we && sel_int1[i]) begin
        int1_d[i] = data_in;
        int0_d[i] = shadow_q[i];
      end
      // A coincident set beats the W1C above
      if (intflag[i]) flag_d[i] = 1'b1;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      txen_q   <= '0;
      rxen_q   <= '0;
      mask_q   <= '0;
      flag_q   <= '0;
      rst_q    <= '0;
      tx_q     <= '{default: '0};
      rx_q     <= '{default: '0};
      shadow_q <= '{default: '0};
      int0_q   <= '{default: '0};
      int1_q   <= '{default: '0};
      dout_q   <= '0;
    end else begin
      txen_q   <= txen_d;
      rxen_q   <= rxen_d;
      mask_q   <= mask_d;
      flag_q   <= flag_d;
      rst_q    <= rst_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      shadow_q <= shadow_d;
      int0_q   <= int0_d;
      int1_q   <= int1_d;
      dout_q   <= dout_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign tx_slot[g*DW +: DW]     = tx_q[g];
    assign rx_slot[g*DW +: DW]     = rx_q[g];
    assign tpuint[g*2*DW +: 2*DW]  = {int1_q[g], int0_q[g]};
  end

  assign txslot_en = txen_q;
  assign rxslot_en = rxen_q;
  assign rsttpu    = rst_q;
  assign data_out  = dout_q;
  assign irq       = |(flag_q & mask_q);

endmodule

// File: tb/tb_tpu_regbank.sv
// Scoreboard bench for tpu_regbank: directed scenarios then randomized traffic against a register-map model.
module tb_tpu_regbank;
  localparam int          NCH  = 4;
  localparam int          DW   = 8;
  localparam int          AW   = 8;
  localparam int unsigned BASE = 32'h20;

  logic                sys_clock = 1'b0;
  logic                reset     = 1'b1;
  logic [DW-1:0]       data_in   = '0;
  logic                we        = 1'b0;
  logic [AW-1:0]       addr      = '0;
  logic [NCH-1:0]      intflag   = '0;
  logic [DW-1:0]       data_out;
  logic [NCH-1:0]      txslot_en, rxslot_en, rsttpu;
  logic [NCH*DW-1:0]   tx_slot, rx_slot;
  logic [NCH*2*DW-1:0] tpuint;
  logic                irq;

  tpu_regbank #(.NCH(NCH), .DW(DW), .AW(AW), .BASE_ADDR(BASE)) dut (
    .sys_clock(sys_clock), .reset(reset), .data_in(data_in), .we(we), .addr(addr),
    .data_out(data_out), .intflag(intflag), .txslot_en(txslot_en), .rxslot_en(rxslot_en),
    .tx_slot(tx_slot), .rx_slot(rx_slot), .tpuint(tpuint), .rsttpu(rsttpu), .irq(irq)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic [DW-1:0]       dout;
    logic [NCH-1:0]      rst, txe, rxe;
    logic                irq;
    logic [NCH*2*DW-1:0] tpuint;
    logic [NCH*DW-1:0]   tx, rx;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Register-map model
  bit            m_txe[NCH], m_rxe[NCH], m_mask[NCH], m_flag[NCH];
  logic [DW-1:0] m_tx[NCH], m_rx[NCH], m_shadow[NCH], m_lo[NCH], m_hi[NCH];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_txe[i] = 0; m_rxe[i] = 0; m_mask[i] = 0; m_flag[i] = 0;
      m_tx[i] = '0; m_rx[i] = '0; m_shadow[i] = '0; m_lo[i] = '0; m_hi[i] = '0;
    end
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    int off;
    r   = '0;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < 8 * NCH) begin
      case (off % 8)
        0: begin
          r[1] = m_txe[off/8]; r[2] = m_rxe[off/8]; r[3] = m_mask[off/8]; r[4] = m_flag[off/8];
        end
        1: r = m_tx[off/8];
        2: r = m_rx[off/8];
        3: r = m_lo[off/8];
        4: r = m_hi[off/8];
        default: r = '0;
      endcase
    end else if (off == 8 * NCH) begin
      for (int i = 0; i < NCH; i++) r[i] = m_flag[i];
    end else if (off == 8 * NCH + 1) begin
      for (int i = 0; i < NCH; i++) r[i] = m_flag[i] & m_mask[i];
    end
    return r;
  endfunction

  // One bus cycle: drive at negedge, predict the state seen after the next rising edge
  task automatic step(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NCH-1:0] f);
    exp_t e;
    int   off, ch;
    @(negedge sys_clock);
    we = w; addr = a; data_in = d; intflag = f;
    e = '{default: '0};
    e.dout = model_read(a);
    off = int'(a) - int'(BASE);
    ch  = off / 8;
    if (w && off >= 0 && off < 8 * NCH) begin
      case (off % 8)
        0: begin
          m_txe[ch] = d[1]; m_rxe[ch] = d[2]; m_mask[ch] = d[3];
          if (d[4]) m_flag[ch] = 0;
          e.rst[ch] = d[0];
        end
        1: m_tx[ch] = d;
        2: m_rx[ch] = d;
        3: m_shadow[ch] = d;
        4: begin m_hi[ch] = d; m_lo[ch] = m_shadow[ch]; end
        default: ;
      endcase
    end
    for (int i = 0; i < NCH; i++) begin
      if (f[i]) m_flag[i] = 1;
      e.txe[i] = m_txe[i];
      e.rxe[i] = m_rxe[i];
      e.irq    = e.irq | (m_flag[i] & m_mask[i]);
      e.tx[i*DW +: DW] = m_tx[i];
      e.rx[i*DW +: DW] = m_rx[i];
      e.tpuint[i*2*DW +: 2*DW] = {m_hi[i], m_lo[i]};
    end
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout"},   data_out, 0);
    chk({tag, "_rsttpu"}, rsttpu, 0);
    chk({tag, "_irq"},    irq, 0);
    chk({tag, "_tpuint"}, tpuint, 0);
    chk({tag, "_txslot"}, tx_slot, 0);
  endtask

  task automatic do_reset();
    @(negedge sys_clock);
    reset = 1'b1; we = 1'b0; intflag = '0;
    model_reset();
    #1;
    check_zero("async_reset");
    @(negedge sys_clock);
    reset = 1'b0;
  endtask

  // Monitor: data_out updates every cycle, so every pending expectation is checked one edge later
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clock);
      if (q.size() > 0) begin
        #1;
        e = q.pop_front();
        chk("data_out",  data_out,  e.dout);
        chk("rsttpu",    rsttpu,    e.rst);
        chk("irq",       irq,       e.irq);
        chk("tpuint",    tpuint,    e.tpuint);
        chk("tx_slot",   tx_slot,   e.tx);
        chk("rx_slot",   rx_slot,   e.rx);
        chk("txslot_en", txslot_en, e.txe);
        chk("rxslot_en", rxslot_en, e.rxe);
      end
    end
  end

  initial begin
    logic [AW-1:0] ra;
    logic [NCH-1:0] rf;
    model_reset();
    #1;
    check_zero("power_on_reset");
    @(negedge sys_clock);
    reset = 1'b0;

    for (int a = BASE; a <= BASE + 8 * NCH + 1; a++) step(0, AW'(a), '0, '0);

    // Channel 2 reset pulse and slot enables
    step(1, 8'h30, 8'h0F, '0);
    step(0, 8'h30, 8'h00, '0);
    step(0, 8'h00, 8'h00, '0);
    step(1, 8'h30, 8'h01, '0);
    step(1, 8'h30, 8'h07, '0);
    step(1, 8'h30, 8'h06, '0);

    // Sticky flag, set beats W1C, then W1C alone
    step(1, 8'h28, 8'h08, '0);
    step(0, 8'h40, 8'h00, 4'b0010);
    step(0, 8'h40, 8'h00, '0);
    step(1, 8'h28, 8'h18, 4'b0010);
    step(0, 8'h28, 8'h00, '0);
    step(1, 8'h28, 8'h10, '0);
    step(1, 8'h28, 8'h08, '0);
    step(1, 8'h28, 8'h18, '0);
    step(0, 8'h41, 8'h00, '0);

    // Atomic interval commit
    step(1, 8'h23, 8'h34, '0);
    step(0, 8'h23, 8'h00, '0);
    step(1, 8'h24, 8'h12, '0);
    step(0, 8'h23, 8'h00, '0);
    step(0, 8'h24, 8'h00, '0);
    step(1, 8'h23, 8'h11, '0);
    step(1, 8'h23, 8'h22, '0);
    step(1, 8'h24, 8'h33, '0);

    // Same-edge read/write of TX ch3
    step(1, 8'h39, 8'hAA, '0);
    step(1, 8'h39, 8'h55, '0);
    step(0, 8'h39, 8'h00, '0);

    // Reset discards an uncommitted shadow and a pending pulse
    step(1, 8'h23, 8'h34, '0);
    do_reset();
    step(1, 8'h24, 8'h12, '0);
    step(1, 8'h20, 8'h01, '0);
    do_reset();
    step(0, 8'h20, 8'h00, '0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) ra = AW'($urandom);
      else ra = AW'(BASE - 2 + $urandom_range(0, 8 * NCH + 5));
      rf = '0;
      for (int i = 0; i < NCH; i++) rf[i] = ($urandom_range(0, 7) == 0);
      step(bit'($urandom_range(0, 1)), ra, DW'($urandom), rf);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    @(negedge sys_clock);
    @(negedge sys_clock);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
